// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned BCD_NIBBLE = 4;

  // Decoder code for "all segments off"; consumers substitute it where blank[i]=1.
  localparam logic [BCD_NIBBLE-1:0] DIGIT_BLANK = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit shift-and-add-3 corrector: nibbles of 5 or more get +3 before the shift.
import bcd_pkg::*;

module bcd_add3 (
  input  logic [BCD_NIBBLE-1:0] nib,
  output logic [BCD_NIBBLE-1:0] nib_c
);

  always_comb begin
    nib_c = (nib >= 4'd5) ? (nib + 4'd3) : nib;
  end

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter, one shift per clock, with sign, leading-zero
// blank mask and overflow flag for the 7-segment display path.
import bcd_pkg::*;

module bcd_convert_seq #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET_N,
  input  logic                       start,
  input  logic [WIDTH-1:0]           bin,
  input  logic                       neg,
  output logic                       busy,
  output logic                       done,
  output logic [BCD_NIBBLE*DIGITS-1:0] bcd,
  output logic                       sign,
  output logic [DIGITS-1:0]          blank,
  output logic                       ovf
);

  localparam int unsigned BCDW = DIGITS * BCD_NIBBLE;
  localparam int unsigned SRW  = BCDW + WIDTH;
  localparam int unsigned CW   = $clog2(WIDTH) + 1;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [SRW-1:0]   sr, sr_d, sr_corr, sr_shift;
  logic             neg_q, neg_d;
  logic             acc, acc_d, acc_next;
  logic             busy_d, done_d, sign_d, ovf_d;
  logic [BCDW-1:0]  bcd_d, dig_new;
  logic [DIGITS-1:0] blank_d, blank_new;

  // Correct every BCD nibble in parallel; the binary tail passes through untouched.
  assign sr_corr[WIDTH-1:0] = sr[WIDTH-1:0];

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib   (sr[WIDTH + g*BCD_NIBBLE +: BCD_NIBBLE]),
      .nib_c (sr_corr[WIDTH + g*BCD_NIBBLE +: BCD_NIBBLE])
    );
  end

  always_comb begin
    sr_shift = {sr_corr[SRW-2:0], 1'b0};
    acc_next = acc | sr_corr[SRW-1];
    dig_new  = sr_shift[SRW-1 -: BCDW];
  end

  // A digit is blanked while it and every digit above it are zero; units never blank.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    blank_new = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (dig_new[i*BCD_NIBBLE +: BCD_NIBBLE] != '0) seen = 1'b1;
      blank_new[i] = ~seen;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sr_d    = sr;
    neg_d   = neg_q;
    acc_d   = acc;
    busy_d  = busy;
    done_d  = 1'b0;
    bcd_d   = bcd;
    sign_d  = sign;
    blank_d = blank;
    ovf_d   = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCDW{1'b0}}, bin};
          neg_d   = neg;
          cnt_d   = '0;
          acc_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        acc_d = acc_next;
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          bcd_d   = dig_new;
          blank_d = blank_new;
          sign_d  = neg_q;
          ovf_d   = acc_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      neg_q <= 1'b0;
      acc   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      sign  <= 1'b0;
      blank <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sr    <= sr_d;
      neg_q <= neg_d;
      acc   <= acc_d;
      busy  <= busy_d;
      done  <= done_d;
      bcd   <= bcd_d;
      sign  <= sign_d;
      blank <= blank_d;
      ovf   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus directed
// literal checks for the default instance and a 14-bit overflow instance.
module tb_bcd_convert_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, neg;
  logic [9:0]  bin;
  logic        busy, done, sign, ovf;
  logic [15:0] bcd;
  logic [3:0]  blank;

  logic        start2, neg2;
  logic [13:0] bin2;
  logic        busy2, done2, sign2, ovf2;
  logic [15:0] bcd2;
  logic [3:0]  blank2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ndone  = 0;

  always #10 clk = ~clk;

  bcd_convert_seq #(.WIDTH(10), .DIGITS(4)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .bin(bin), .neg(neg),
    .busy(busy), .done(done), .bcd(bcd), .sign(sign), .blank(blank), .ovf(ovf)
  );

  bcd_convert_seq #(.WIDTH(14), .DIGITS(4)) dut14 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start2), .bin(bin2), .neg(neg2),
    .busy(busy2), .done(done2), .bcd(bcd2), .sign(sign2), .blank(blank2), .ovf(ovf2)
  );

  // Reference: decimal digits by division, blank by counting significant digits.
  function automatic logic [15:0] m_bcd_of(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] m_blank_of(input int v);
    int l, nd;
    logic [3:0] r;
    l  = v % 10000;
    nd = 1;
    while (l >= 10) begin
      l  = l / 10;
      nd = nd + 1;
    end
    for (int i = 0; i < 4; i++) r[i] = (i >= nd);
    return r;
  endfunction

  int          m_left, m_val;
  logic        m_neg, m_busy, m_done, m_sign, m_ovf;
  logic [15:0] m_bcd;
  logic [3:0]  m_blank;

  // Transaction-level timing model: WIDTH cycles after accept, results appear.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_bcd <= '0;
      m_sign <= 1'b0; m_blank <= '0; m_ovf <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_val  <= int'(bin);
          m_neg  <= neg;
          m_left <= 10;
          m_busy <= 1'b1;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_bcd   <= m_bcd_of(m_val);
          m_blank <= m_blank_of(m_val);
          m_sign  <= m_neg;
          m_ovf   <= (m_val >= 10000);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock; compare against the model on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (done) ndone++;
    chk("busy",  32'(busy),  32'(m_busy));
    chk("done",  32'(done),  32'(m_done));
    chk("bcd",   32'(bcd),   32'(m_bcd));
    chk("sign",  32'(sign),  32'(m_sign));
    chk("blank", 32'(blank), 32'(m_blank));
    chk("ovf",   32'(ovf),   32'(m_ovf));
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done && n < maxc);
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic convert(input logic [9:0] v, input logic s, output int n);
    start = 1'b1; bin = v; neg = s;
    step();
    start = 1'b0;
    wait_done(40, n);
  endtask

  initial begin
    int n, c1;
    rst_n = 1'b0; start = 1'b0; bin = '0; neg = 1'b0;
    start2 = 1'b0; bin2 = '0; neg2 = 1'b0;
    step(); step();
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_blank", 32'(blank), 32'h0);
    chk("rst_busy2", 32'(busy2), 32'h0);
    rst_n = 1'b1;
    step();

    convert(10'd1023, 1'b0, n);
    chk("lat_1023", 32'(n), 32'd10);
    chk("bcd_1023", 32'(bcd), 32'h1023);
    chk("blank_1023", 32'(blank), 32'h0);
    chk("sign_1023", 32'(sign), 32'h0);
    chk("ovf_1023", 32'(ovf), 32'h0);

    convert(10'd0, 1'b0, n);
    chk("bcd_0", 32'(bcd), 32'h0);
    chk("blank_0", 32'(blank), 32'b1110);
    convert(10'd37, 1'b1, n);
    chk("bcd_37", 32'(bcd), 32'h0037);
    chk("blank_37", 32'(blank), 32'b1100);
    chk("sign_37", 32'(sign), 32'h1);

    // Starts during a conversion must be ignored.
    ndone = 0;
    start = 1'b1; bin = 10'd500; neg = 1'b0;
    step();
    n = 0;
    while (!done && n < 40) begin
      n++;
      start = (n == 3 || n == 9);
      bin   = start ? 10'd7 : 10'd500;
      step();
    end
    start = 1'b0;
    chk("lat_500", 32'(n), 32'd10);
    chk("bcd_500", 32'(bcd), 32'h0500);
    repeat (12) step();
    chk("ndone_500", 32'(ndone), 32'd1);

    // Reset in the middle of a conversion.
    start = 1'b1; bin = 10'd999;
    step();
    start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_bcd", 32'(bcd), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_blank", 32'(blank), 32'h0);
    ndone = 0;
    repeat (15) step();
    chk("midrst_nodone", 32'(ndone), 32'd0);
    convert(10'd42, 1'b0, n);
    chk("lat_42", 32'(n), 32'd10);
    chk("bcd_42", 32'(bcd), 32'h0042);

    // Back-to-back requests with start held high.
    start = 1'b1; bin = 10'd123;
    step();
    bin = 10'd456;
    wait_done(40, n);
    chk("bcd_123", 32'(bcd), 32'h0123);
    c1 = cyc;
    step();
    start = 1'b0;
    wait_done(40, n);
    chk("bcd_456", 32'(bcd), 32'h0456);
    chk("b2b_gap", 32'(cyc - c1), 32'd11);

    // Wide instance: 10000 does not fit in four digits.
    start2 = 1'b1; bin2 = 14'd10000; neg2 = 1'b0;
    step();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 40) begin
      step();
      n++;
    end
    chk("lat_w14", 32'(n), 32'd14);
    chk("done_w14", 32'(done2), 32'd1);
    chk("ovf_w14", 32'(ovf2), 32'd1);
    chk("bcd_w14", 32'(bcd2), 32'h0000);
    chk("blank_w14", 32'(blank2), 32'b1110);
    step();
    chk("done_w14_pulse", 32'(done2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_convert_seq.md
# bcd_convert_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock). It sits between the arithmetic stage, which produces the 10-bit result and the negative flag, and the per-digit 7-segment decoders. It turns the result into four packed decimal digits, a sign flag and a leading-zero blank mask, so the divide/modulo chains in the display path are no longer needed.

## Interface
Parameters:
- WIDTH, 10, binary input width; also the number of shift steps per conversion.
- DIGITS, 4, number of BCD output digits.

Ports:
- CLOCK_50  in  1  single clock; all logic rises on posedge.
- RESET_N  in  1  reset, synchronous, active-low.
- start  in  1  request a conversion; sampled only in IDLE.
- bin  in  WIDTH  unsigned magnitude to convert; captured on the accepted start.
- neg  in  1  sign of the value (1 = negative); captured with bin.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new outputs are valid.
- bcd  out  4*DIGITS  packed digits; digit 0 (units) is bcd[3:0].
- sign  out  1  registered copy of the captured neg.
- blank  out  DIGITS  bit i = 1 when digit i is a leading zero; bit 0 is always 0.
- ovf  out  1  value did not fit in DIGITS digits.

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: conversion in progress.
- IDLE, start=1:
  - load shift register with {DIGITS*4 zeros, bin};
  - capture neg;
  - clear step counter and overflow accumulator;
  - set busy=1; next state SHIFT.
- IDLE, start=0: hold; all outputs keep their last value.
- SHIFT, each edge:
  - every BCD nibble ≥5 gets +3;
  - then the whole register shifts left by 1;
  - a 1 shifted out of the top nibble sets the overflow accumulator;
  - step counter +1.
- Final step (counter = WIDTH-1), on the same edge:
  - write the post-shift BCD field to bcd;
  - compute blank from the new digits;
  - drive sign = captured neg and ovf = accumulator;
  - done=1, busy=0; next state IDLE.
- blank computation: scan from digit DIGITS-1 downward; each digit is blanked while it and every higher digit is 0. A zero value therefore gives blank = 1110 for DIGITS=4.
- start while busy: ignored, with no queueing and no effect on the running conversion.
- bin or neg changing during SHIFT: no effect, because both were captured at accept.
- Reset (RESET_N=0 at an edge), in any state including mid-SHIFT:
  - state IDLE, counter 0, shift register 0;
  - bcd=0, sign=0, blank=0, ovf=0, busy=0, done=0.
- Arithmetic: add-3 is per nibble with no inter-nibble carry; counter width is clog2(WIDTH)+1.
- Overflow: with the default parameters (1023 < 10000) ovf can never be set. It is only meaningful when WIDTH is large enough to exceed 10^DIGITS-1.

## Timing
- Start accepted at edge k, then:
  - busy=1 from after edge k through edge k+WIDTH;
  - done=1 for exactly the cycle after edge k+WIDTH.
- Latency is WIDTH cycles from the accepting edge to valid outputs; the default is 10.
- Throughput:
  - The earliest next accept is edge k+WIDTH+1, which is the cycle in which done is high.
  - Back-to-back requests therefore complete every WIDTH+1 cycles.
- Outputs are fully registered and change only on the final-step edge or on reset, so the downstream decoders always see stable digits.

## Structure
- Package bcd_pkg holds:
  - the state enum {IDLE, SHIFT};
  - constant BCD_NIBBLE = 4;
  - constant DIGIT_BLANK = 4'hF, which the decoder maps to all segments off and which consumers substitute where blank[i]=1.
- One sub-module, bcd_add3: a 4-bit combinational corrector (≥5 → +3), instantiated DIGITS times in a generate loop.
- The FSM, counter, shift register and output registers live in the top module.

## Test plan
- Convert bin=1023, neg=0: done after exactly 10 cycles; bcd=16'h1023, blank=0000, sign=0, ovf=0.
- Convert bin=0: bcd=16'h0000, blank=1110. Then convert bin=37, neg=1: bcd=16'h0037, blank=1100, sign=1.
- Start bin=500; pulse start with bin=7 at cycles 3 and 9 of the conversion: the second request is ignored and the result is 16'h0500, with only one done pulse.
- Assert RESET_N=0 at cycle 5 of converting 999: all outputs 0, no done pulse. The next start with bin=42 yields 16'h0042 after 10 cycles.
- Back-to-back: hold start=1 with bin 123 then 456: done pulses 11 cycles apart, with values 16'h0123 then 16'h0456.
- Instance WIDTH=14, DIGITS=4 with bin=10000: ovf=1, and bcd holds the low four digits (16'h0000).
